// File: rtl/regfile_scan.sv
// Register-file debug scanner: walks first..last (with wrap), snapshots each
// register and streams (addr, data) words out on a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start, abort    scan request (IDLE only) / synchronous cancel
//   first_addr      first register of the scan, sampled with start
//   last_addr       last register of the scan, sampled with start
//   scan_addr       read address to the register file
//   scan_data       combinational read data from the register file
//   out_valid       out_addr/out_data hold a captured word
//   out_ready       downstream accepts the word
//   out_addr        register number of the presented word
//   out_data        captured register value
//   busy            high in FETCH, HOLD and DONE
//   done            one-cycle pulse after the last word is accepted
module regfile_scan #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] scan_addr,
    input  logic [DATA_W-1:0] scan_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;

    // Counter wraps naturally at 2**ADDR_W, giving the first..31, 0..last walk.
    logic [ADDR_W-1:0] cnt_d;
    logic              hs;

    assign cnt_d = cnt_q + ADDR_W'(1);
    assign hs    = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            end_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Abort wins over a same-cycle handshake; the pending word is dropped.
            if (abort && state_q != IDLE) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            cnt_q   <= first_addr;
                            end_q   <= last_addr;
                            busy_q  <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                    FETCH: begin
                        out_data_q  <= scan_data;
                        out_addr_q  <= cnt_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                    HOLD: begin
                        if (hs) begin
                            out_valid_q <= 1'b0;
                            if (out_addr_q == end_q) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                cnt_q   <= cnt_d;
                                state_q <= FETCH;
                            end
                        end
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign scan_addr = cnt_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_scan.sv
// Scoreboard bench for regfile_scan: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted word.
module tb_regfile_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic [4:0]  scan_addr;
    logic [4:0]  out_addr;
    logic [31:0] scan_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } word_t;

    word_t expq[$];
    word_t w;
    word_t held;
    logic  held_v = 1'b0;
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    assign scan_data = regs[scan_addr];

    regfile_scan #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .first_addr(first_addr),
        .last_addr(last_addr),
        .scan_addr(scan_addr),
        .scan_data(scan_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr(out_addr),
        .out_data(out_data),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: handshake is decided at negedge, takes effect at the next posedge.
    always @(negedge clk) begin
        if (out_valid && held_v) begin
            chk("stable_addr", {59'd0, out_addr}, {59'd0, held.a});
            chk("stable_data", {32'd0, out_data}, {32'd0, held.d});
        end
        held_v = 1'b0;
        if (out_valid && rst && !abort) begin
            if (out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h/%0h want none", out_addr, out_data);
                end else begin
                    w = expq.pop_front();
                    chk("word_addr", {59'd0, out_addr}, {59'd0, w.a});
                    chk("word_data", {32'd0, out_data}, {32'd0, w.d});
                end
            end else begin
                held_v = 1'b1;
                held = {out_addr, out_data};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [4:0] f, input logic [4:0] l, input bit rnd);
        int  k;
        int  idx;
        bit  seen;
        logic [4:0] a;
        k = int'(5'(l - f)) + 1;
        for (int i = 0; i < k; i++) begin
            a = 5'(int'(f) + i);
            expq.push_back({a, regs[a]});
        end
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        out_ready  = !rnd;
        seen = 1'b0;
        idx  = 0;
        tick();
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("scan_addr_first", {59'd0, scan_addr}, {59'd0, f});
        start = 1'b0;
        while (!seen && idx < 400) begin
            if (rnd) begin
                out_ready  = 1'($urandom_range(0, 1));
                start      = ($urandom_range(0, 3) == 0);
                first_addr = 5'($urandom_range(0, 31));
                last_addr  = first_addr;
            end
            tick();
            idx++;
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        if (seen && !rnd)
            chk("done_edge", 64'(idx), 64'(2 * k));
        tick();
        chk("idle_after_done", {63'd0, busy}, 64'd0);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("queue_empty", 64'(expq.size()), 64'd0);
        out_ready = 1'b0;
    endtask

    task automatic snapshot();
        int n;
        bit seen;
        regs[7] = 32'h12345678;
        expq.push_back({5'd7, 32'h12345678});
        first_addr = 5'd7;
        last_addr  = 5'd7;
        start      = 1'b1;
        out_ready  = 1'b0;
        tick();
        start = 1'b0;
        tick();
        regs[7] = 32'h9ABCDEF0;
        tick();
        tick();
        chk("snap_held", {32'd0, out_data}, {32'd0, 32'h12345678});
        out_ready = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = done;
        end
        chk("snap_done", {63'd0, seen}, 64'd1);
        out_ready = 1'b0;
        tick();
        chk("snap_queue_empty", 64'(expq.size()), 64'd0);
    endtask

    task automatic kill_scan(input bit use_rst);
        int dn;
        expq.push_back({5'd0, regs[0]});
        expq.push_back({5'd1, regs[1]});
        first_addr = 5'd0;
        last_addr  = 5'd7;
        start      = 1'b1;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("hold_before_kill", {63'd0, out_valid}, 64'd1);
        if (use_rst) rst = 1'b0;
        else abort = 1'b1;
        tick();
        abort = 1'b0;
        rst   = 1'b1;
        chk("kill_valid_low", {63'd0, out_valid}, 64'd0);
        chk("kill_idle", {63'd0, busy}, 64'd0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dn++;
            tick();
        end
        chk("kill_no_done", 64'(dn), 64'd0);
        chk("kill_queue_empty", 64'(expq.size()), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            regs[i] = (i == 0) ? 32'd0 : (32'hC0DE0000 | (32'(i) * 32'h00000101));
        regs[5] = 32'hA5A5A5A5;
        regs[6] = 32'h55AA55AA;
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_addr", {59'd0, out_addr}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_scan_addr", {59'd0, scan_addr}, 64'd0);
        rst = 1'b1;
        tick();
        scan(5'd5, 5'd6, 1'b0);
        scan(5'd0, 5'd31, 1'b0);
        scan(5'd30, 5'd1, 1'b0);
        scan(5'd3, 5'd3, 1'b1);
        scan(5'd0, 5'd7, 1'b1);
        snapshot();
        kill_scan(1'b0);
        scan(5'd5, 5'd6, 1'b0);
        kill_scan(1'b1);
        scan(5'd5, 5'd6, 1'b0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scan.md
# regfile_scan

Debug read-out engine sitting on a spare read port of the CPU register file (`Regs`). On a start request it walks a range of register addresses, captures each 32-bit value, and presents it with its address on a valid/ready stream toward the display or UART debug path. It is the consumer end of the register-file port; it never writes the register file.

## Interface
- `ADDR_W`, 5, register address width (32 registers).
- `DATA_W`, 32, register data width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; ends a scan without `done`.
- `first_addr`  in  ADDR_W  first register of the scan; sampled with `start`.
- `last_addr`  in  ADDR_W  last register of the scan; sampled with `start`.
- `scan_addr`  out  ADDR_W  address to the register-file read port (`R_addr_*`).
- `scan_data`  in  DATA_W  combinational read data from the register file (`rdata_*`).
- `out_valid`  out  1  `out_addr`/`out_data` hold a captured word.
- `out_ready`  in  1  downstream accepts the word.
- `out_addr`  out  ADDR_W  register number of the presented word.
- `out_data`  out  DATA_W  captured register value.
- `busy`  out  1  high in FETCH, HOLD and DONE.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, FETCH, HOLD, DONE.
- IDLE: `start`=1 latches `first_addr` into the address counter and `last_addr` into the end register, then moves to FETCH. `start` is ignored in all other states.
- FETCH: `scan_addr` drives the counter value. On the next edge, `scan_data` is captured into `out_data` and the counter into `out_addr`, `out_valid` is set, and the state moves to HOLD.
- HOLD: `out_valid`=1. `out_addr` and `out_data` stay stable until the handshake (`out_valid`&`out_ready` at an edge).
  - On handshake with `out_addr`==end: clear `out_valid`, go to DONE.
  - On handshake otherwise: counter = counter+1 mod 32, clear `out_valid`, go to FETCH.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- Wrap-around: if `last_addr` < `first_addr`, the scan runs first..31, then 0..last. The word count is ((last−first) mod 32)+1. If first==last, exactly one word is sent.
- Snapshot semantics: each word is the register value at its capture edge. Register writes after that edge are not reflected in the word.
- `abort`=1 in any non-IDLE state: the next state is IDLE, `out_valid` is cleared, `done` is not pulsed, and a pending word is dropped. `abort` has priority over a handshake in the same cycle.
- `rst`=0 has priority over everything and returns the block to IDLE.
- `scan_addr` equals the counter in every state. Its value in IDLE is don't-care but must be held stable.

## Timing
- Reset values: `out_valid`=0, `done`=0, `busy`=0, `out_addr`=0, `out_data`=0, `scan_addr`=0, state IDLE.
- Edge E0 samples `start`=1. `busy`=1 and `scan_addr`=first from E0. At E1 the word is captured and `out_valid`=1.
- With `out_ready` held high, the handshake happens at E2 and the next word is valid after E3. Throughput is 1 word per 2 cycles.
- For k words with `out_ready` held high, the final handshake is at edge E(2k). `done`=1 in the cycle after E(2k), and `busy`=0 after E(2k+1).
- Back-pressure: each cycle with `out_ready`=0 in HOLD adds one cycle. No word is lost or duplicated.
- Ready-before-valid is legal. `out_ready`=1 while in FETCH has no effect.
- A new `start` is accepted earliest at the first IDLE cycle after DONE.

## Test plan
- Preload r5=A5A5A5A5, r6=55AA55AA, scan 5..6 with ready=1 → words (05,A5A5A5A5), (06,55AA55AA); `done` 1 cycle after E4.
- Full scan 0..31 with ready=1 → 32 words in address order; out(00) = 00000000 (r0); `done` after E64; no `out_valid` gaps longer than 1 cycle.
- Wrap scan 30..1 → addresses 1E, 1F, 00, 01 in that order, then `done`; 4 words total.
- Ready toggled randomly during scan 3..3 and 0..7 → each word is held stable while stalled; exactly one acceptance per address; `start` pulses during busy are ignored.
- Write r7=12345678 at the capture edge of r7, then 9ABCDEF0 before the handshake → `out_data`=12345678 is held until accepted.
- `abort` mid-scan (HOLD, ready=1 same cycle), and separately `rst`=0 mid-scan → `out_valid` low next cycle, no `done`, IDLE; a new `start` then works normally.
